// File: rtl/execute_cycle.sv
// rtl/execute_cycle.sv - EX stage: forwarding, ALU, branch resolve, squash window, EX/MEM register
// A taken redirect squashes the two younger instructions already in flight behind it.
module execute_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic        ResultSrcE,
  input  logic        ALUSrcE,
  input  logic        BranchE,
  input  logic        JumpE,
  input  logic [3:0]  ALUControlE,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] Imm_Ext_E,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RS1_E,
  input  logic [4:0]  RS2_E,
  input  logic [4:0]  RD_E,
  input  logic [31:0] ResultW,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        ResultSrcM,
  output logic [4:0]  RD_M,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M
);

  logic [1:0]  sq;
  logic        live;
  logic [31:0] src_a;
  logic [31:0] src_b_fwd;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic        zero;
  logic [4:0]  shamt;

  // M stage is the younger producer, so it wins over W; x0 is never forwarded.
  always_comb begin
    src_a = RD1_E;
    if (RegWriteM && (RD_M == RS1_E) && (RS1_E != 5'd0))
      src_a = ALUResultM;
    else if (RegWriteW && (RDW == RS1_E) && (RS1_E != 5'd0))
      src_a = ResultW;
  end

  always_comb begin
    src_b_fwd = RD2_E;
    if (RegWriteM && (RD_M == RS2_E) && (RS2_E != 5'd0))
      src_b_fwd = ALUResultM;
    else if (RegWriteW && (RDW == RS2_E) && (RS2_E != 5'd0))
      src_b_fwd = ResultW;
  end

  assign src_b = ALUSrcE ? Imm_Ext_E : src_b_fwd;
  assign shamt = src_b[4:0];

  always_comb begin
    alu_result = 32'd0;
    case (ALUControlE)
      4'b0000: alu_result = src_a + src_b;
      4'b0001: alu_result = src_a - src_b;
      4'b0010: alu_result = src_a & src_b;
      4'b0011: alu_result = src_a | src_b;
      4'b0100: alu_result = src_a ^ src_b;
      4'b0101: alu_result = src_a << shamt;
      4'b0110: alu_result = src_a >> shamt;
      4'b0111: alu_result = $signed(src_a) >>> shamt;
      4'b1000: alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
      4'b1001: alu_result = {31'd0, src_a < src_b};
      default: alu_result = 32'd0;
    endcase
  end

  assign zero      = (alu_result == 32'd0);
  assign live      = (sq == 2'd0);
  assign PCSrcE    = live & ((BranchE & zero) | JumpE);
  assign PCTargetE = PCE + Imm_Ext_E;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sq         <= 2'd0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      RD_M       <= 5'd0;
      ALUResultM <= 32'd0;
      WriteDataM <= 32'd0;
      PCPlus4M   <= 32'd0;
    end else begin
      if (PCSrcE)
        sq <= 2'd2;
      else if (sq != 2'd0)
        sq <= sq - 2'd1;
      RegWriteM  <= RegWriteE & live;
      MemWriteM  <= MemWriteE & live;
      ResultSrcM <= ResultSrcE & live;
      RD_M       <= RD_E;
      ALUResultM <= alu_result;
      WriteDataM <= src_b_fwd;
      PCPlus4M   <= PCPlus4E;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// tb/tb_execute_cycle.sv - directed checks for execute_cycle
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, JumpE;
  logic [3:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RS1_E, RS2_E, RD_E, RDW;
  logic        RegWriteW;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

  int passed = 0;
  int total  = 0;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .ALUSrcE(ALUSrcE), .BranchE(BranchE), .JumpE(JumpE),
    .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
    .ResultW(ResultW), .RegWriteW(RegWriteW), .RDW(RDW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; ALUSrcE = 0; BranchE = 0; JumpE = 0;
    ALUControlE = 4'b0000; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0;
    RS1_E = 0; RS2_E = 0; RD_E = 0; ResultW = 0; RegWriteW = 0; RDW = 0;
  endtask

  task automatic check_m_zero(input string tag);
    check({tag, "_regwrite"}, {31'd0, RegWriteM}, 32'd0);
    check({tag, "_memwrite"}, {31'd0, MemWriteM}, 32'd0);
    check({tag, "_resultsrc"}, {31'd0, ResultSrcM}, 32'd0);
    check({tag, "_rd"}, {27'd0, RD_M}, 32'd0);
    check({tag, "_alu"}, ALUResultM, 32'd0);
    check({tag, "_wdata"}, WriteDataM, 32'd0);
    check({tag, "_pc4"}, PCPlus4M, 32'd0);
  endtask

  logic [3:0]  v_op  [8] = '{4'b1000, 4'b1001, 4'b0111, 4'b0101, 4'b0110, 4'b0100, 4'b0010, 4'b1111};
  logic [31:0] v_a   [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h00000003, 32'h80000000, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h12345678};
  logic [31:0] v_b   [8] = '{32'd1, 32'd1, 32'd4, 32'd36, 32'd4, 32'hFF00FF00, 32'hFF00FF00, 32'd1};
  logic [31:0] v_exp [8] = '{32'd1, 32'd0, 32'hF8000000, 32'h00000030, 32'h08000000, 32'h0FF00FF0, 32'hF000F000, 32'd0};

  initial begin
    rst = 0;
    nop();
    JumpE = 1; PCE = 32'h200; Imm_Ext_E = 32'h10;
    #2;
    check_m_zero("reset");
    check("reset_pcsrc", {31'd0, PCSrcE}, 32'd1);
    check("reset_target", PCTargetE, 32'h210);
    #10;
    rst = 1;

    // ADD 5+7 -> x3
    nop();
    RD1_E = 5; RD2_E = 7; RD_E = 3; RegWriteE = 1; PCPlus4E = 32'h8;
    tick();
    check("add_result", ALUResultM, 32'd12);
    check("add_rd", {27'd0, RD_M}, 32'd3);
    check("add_regwrite", {31'd0, RegWriteM}, 32'd1);
    check("add_wdata", WriteDataM, 32'd7);
    check("add_pc4", PCPlus4M, 32'h8);

    // SUB x3(=12 from M) - 2, with a competing W write of x3
    nop();
    ALUControlE = 4'b0001; RS1_E = 3; RD1_E = 0; RD2_E = 2; RD_E = 4; RegWriteE = 1;
    RegWriteW = 1; RDW = 3; ResultW = 99;
    tick();
    check("fwd_m_priority", ALUResultM, 32'd10);

    // A from W (x3=99), B from M (x4=10)
    nop();
    RS1_E = 3; RS2_E = 4; RD_E = 5; RegWriteW = 1; RDW = 3; ResultW = 99;
    tick();
    check("fwd_w_a_m_b", ALUResultM, 32'd109);
    check("fwd_m_wdata", WriteDataM, 32'd10);

    // Write to x0 then read x0
    nop();
    RD1_E = 1; RD2_E = 1; RD_E = 0; RegWriteE = 1;
    tick();
    nop();
    RD1_E = 4; RegWriteW = 1; RDW = 0; ResultW = 99;
    tick();
    check("x0_no_fwd", ALUResultM, 32'd4);

    // Immediate operand; forwarded register still goes to store data
    nop();
    ALUSrcE = 1; RD1_E = 10; Imm_Ext_E = 5; RD2_E = 100;
    tick();
    check("imm_result", ALUResultM, 32'd15);
    check("imm_wdata", WriteDataM, 32'd100);

    foreach (v_op[i]) begin
      nop();
      ALUControlE = v_op[i]; RD1_E = v_a[i]; RD2_E = v_b[i];
      tick();
      check($sformatf("alu_vec%0d", i), ALUResultM, v_exp[i]);
    end

    // Wrap-around ADD gives Zero; observe it through BranchE without letting it retire taken
    nop();
    RD1_E = 32'hFFFFFFFF; RD2_E = 1; BranchE = 1;
    #1;
    check("wrap_zero_pcsrc", {31'd0, PCSrcE}, 32'd1);
    BranchE = 0;
    #1;
    check("wrap_nobranch_pcsrc", {31'd0, PCSrcE}, 32'd0);
    tick();
    check("wrap_result", ALUResultM, 32'd0);

    nop();
    ALUControlE = 4'b0001; RD1_E = 6; RD2_E = 7; BranchE = 1;
    #1;
    check("bne_not_taken", {31'd0, PCSrcE}, 32'd0);

    // Taken BEQ, then two squashed instructions, then a live one
    nop();
    ALUControlE = 4'b0001; RD1_E = 6; RD2_E = 6; BranchE = 1; PCE = 32'h100; Imm_Ext_E = 32'h20;
    #1;
    check("beq_pcsrc", {31'd0, PCSrcE}, 32'd1);
    check("beq_target", PCTargetE, 32'h120);
    tick();
    for (int k = 0; k < 2; k++) begin
      nop();
      RegWriteE = 1; MemWriteE = 1; JumpE = 1; RD_E = 7; RD1_E = 1; RD2_E = 2;
      #1;
      check($sformatf("squash%0d_pcsrc", k), {31'd0, PCSrcE}, 32'd0);
      tick();
      check($sformatf("squash%0d_regwrite", k), {31'd0, RegWriteM}, 32'd0);
      check($sformatf("squash%0d_memwrite", k), {31'd0, MemWriteM}, 32'd0);
    end
    #1;
    check("live_pcsrc", {31'd0, PCSrcE}, 32'd1);
    tick();
    check("live_regwrite", {31'd0, RegWriteM}, 32'd1);
    check("live_result", ALUResultM, 32'd3);

    // Reset in the middle of the squash window
    #2;
    rst = 0;
    #1;
    check_m_zero("midsquash");
    check("midsquash_pcsrc", {31'd0, PCSrcE}, 32'd1);
    #2;
    rst = 1;
    nop();
    RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1; RD_E = 9; RD1_E = 3; RD2_E = 4; PCPlus4E = 32'h44;
    tick();
    check("post_rst_regwrite", {31'd0, RegWriteM}, 32'd1);
    check("post_rst_memwrite", {31'd0, MemWriteM}, 32'd1);
    check("post_rst_resultsrc", {31'd0, ResultSrcM}, 32'd1);
    check("post_rst_result", ALUResultM, 32'd7);
    check("post_rst_pc4", PCPlus4M, 32'h44);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/execute_cycle.md
EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst  in  1  reset; asynchronous, active-low.
REQ-003 RegWriteE, MemWriteE, ResultSrcE  in  1 each  write-enable, store and load-result controls of the instruction in E.
REQ-004 ALUSrcE, BranchE, JumpE  in  1 each  select Imm_Ext_E as ALU B; BEQ-type branch; unconditional jump.
REQ-005 ALUControlE  in  4  ALU operation code.
REQ-006 RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  in  32 each  operands, immediate, PC and PC+4 of the instruction in E.
REQ-007 RS1_E, RS2_E, RD_E  in  5 each  source and destination register numbers.
REQ-008 ResultW  in  32;  RegWriteW  in  1;  RDW  in  5  writeback result, enable and destination.
REQ-009 PCSrcE  out  1  redirect fetch to PCTargetE (combinational).
REQ-010 PCTargetE  out  32  PCE + Imm_Ext_E (combinational).
REQ-011 RegWriteM, MemWriteM, ResultSrcM  out  1 each  registered controls for M.
REQ-012 RD_M  out  5;  ALUResultM, WriteDataM, PCPlus4M  out  32 each  registered EX/MEM payload.

Function
REQ-013 Operand A: ALUResultM if RegWriteM & RD_M==RS1_E & RS1_E!=0; else ResultW if RegWriteW & RDW==RS1_E & RS1_E!=0; else RD1_E. M takes priority over W.
REQ-014 Forwarded B (SrcB_fwd): same rule on RS2_E/RD2_E; ALU B = Imm_Ext_E if ALUSrcE else SrcB_fwd.
REQ-015 ALU, 32-bit, wrap-around, no flags except Zero: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT signed, 1001 SLTU; shift amount B[4:0]; other codes give 0.
REQ-016 Zero = (ALU result == 0).
REQ-017 Squash counter sq, 2 bits, values 0..2; instruction in E is live iff sq==0.
REQ-018 PCSrcE = live & ((BranchE & Zero) | JumpE); PCTargetE is driven regardless of PCSrcE.
REQ-019 On a clock edge with PCSrcE=1: sq <= 2. Otherwise with sq!=0: sq <= sq-1. Otherwise sq holds at 0.
REQ-020 Every edge: RD_M<=RD_E, ALUResultM<=ALU result, WriteDataM<=SrcB_fwd, PCPlus4M<=PCPlus4E; RegWriteM<=RegWriteE&live, MemWriteM<=MemWriteE&live, ResultSrcM<=ResultSrcE&live.
REQ-021 Latency: one cycle E->M; PCSrcE/PCTargetE resolve in the same cycle as the E inputs.
REQ-022 A squashed instruction has no architectural effect: no register write, no store, no redirect, and it never becomes a forwarding source (RegWriteM=0).
REQ-023 No stall port; load-use hazards are not interlocked and are left to the instruction stream (one independent instruction after a load).

Reset
REQ-024 rst=0 asynchronously clears sq to 0 and every M output (RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M) to 0; this holds even mid-squash.
REQ-025 During reset, PCSrcE and PCTargetE follow REQ-018/REQ-010 with sq=0; on release, the first edge captures normally.

Verification
REQ-026 ADD with RD1_E=5, RD2_E=7, ALUControlE=0000, RD_E=3, RegWriteE=1 -> next cycle ALUResultM=12, RD_M=3, RegWriteM=1.
REQ-027 Back-to-back dependence: ADD x3=12 in M, then SUB RS1_E=3, RD1_E=0, RD2_E=2 -> ALUResultM=10 (M forward). With RegWriteW=1, RDW=3, ResultW=99 at the same time, the M value still wins.
REQ-028 Writes to x0: RD_M=0 with RegWriteM=1 and RS1_E=0, RD1_E=4 -> operand A=4, no forwarding.
REQ-029 BEQ with equal operands, PCE=0x100, Imm=0x20 -> PCSrcE=1, PCTargetE=0x120. The next two E instructions (RegWriteE=1, JumpE=1) give RegWriteM=0 and PCSrcE=0. The third is live.
REQ-030 SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0; SRA 0x80000000 by 4 -> 0xF8000000; ADD 0xFFFFFFFF+1 -> 0, Zero=1.
REQ-031 Assert rst=0 one cycle after a taken jump (sq=2) -> all M outputs 0 immediately. After release, the next instruction is live.
